pipe_control_unit: RTL and testbench
====================================

// Module: pipe_control_unit
// PURPOSE
//  Parametrised, pipelined successor to the single-cycle decoder. Decodes Opcode/Funct in ID and
//  carries the control bundle through ID/EX, EX/MEM and MEM/WB registers. Adds load-use stall,
//  branch/jump flush, illegal-opcode trapping and saturating stall/flush counters. Sits between
//  the IF/ID register and the datapath stage muxes.
// PARAMETERS
//  ALU_W    3  ALUControl width (codes below use the low 3 bits, zero-extended)
//  REG_W    5  register-address width
//  CNT_W    16 width of the StallCnt/FlushCnt performance counters
//  HAZ_EN   1  1 = load-use detection active; 0 = StallF/StallD tied to 0
// PORTS
//  CLK           in   1      rising-edge clock
//  RST_N         in   1      asynchronous active-low reset
//  Opcode        in   6      ID-stage instr[31:26]
//  Funct         in   6      ID-stage instr[5:0]
//  RsD, RtD      in   REG_W  ID-stage source registers
//  RtE           in   REG_W  EX-stage rt (load destination)
//  BranchTakenE  in   1      EX-stage branch resolved taken
//  JumpD         out  1      combinational: ID instr is j (PC mux select)
//  StallF,StallD out  1      combinational: hold PC and IF/ID
//  FlushD        out  1      combinational: clear IF/ID on next edge
//  ALUControlE   out  ALU_W  EX ALU operation
//  ALUMUXInSelE  out  1      EX ALU B select (1 = immediate)
//  RFDSelInE     out  1      EX write-register select (1 = rd, 0 = rt)
//  BranchE       out  1      EX instr is beq
//  RFWEM, DMWEM  out  1      MEM register-write enable / data-memory write enable
//  RFWEW         out  1      WB register-file write enable
//  MtoRFSelW     out  1      WB result select (1 = memory)
//  IllegalOp     out  1      sticky illegal-opcode flag
//  StallCnt      out  CNT_W  load-use stall cycles, saturating
//  FlushCnt      out  CNT_W  flush cycles, saturating
// BEHAVIOUR
//  Decode table (ID, combinational): fields are RFWE, DMWE, ALUSrc, MtoRF, RegDst, Branch, ALU.
//   R-type, Opcode 0:
//     add  Funct 0x20: 1 0 0 0 1 0 000
//     sub  Funct 0x22: 1 0 0 0 1 0 010
//     sll  Funct 0x00: 1 0 0 0 1 0 101
//     sllv Funct 0x04: 1 0 0 0 1 0 110
//     srav Funct 0x07: 1 0 0 0 1 0 111
//   I-type:
//     lw   0x23: 1 0 1 1 0 0 000
//     sw   0x2B: 0 1 1 0 0 0 000
//     addi 0x08: 1 0 1 0 0 0 000
//     beq  0x04: 0 0 0 0 0 1 010
//     j    0x02: all 0, JumpD = 1
//   Illegal: any other Opcode, or Opcode 0 with any other Funct. Decodes as a bubble (all fields 0).
//   No X outputs anywhere.
//  Bubble: all control bits 0, ALU field 0.
//  Reset: RST_N low asynchronously clears every pipeline register to a bubble, IllegalOp to 0 and
//   both counters to 0. All registered outputs read 0 during reset. Asserting reset mid-operation
//   discards all in-flight control state.
//  Latency: decoded fields appear on the E outputs 1 cycle after ID, M outputs after 2, W after 3.
//   The EX/MEM and MEM/WB registers always advance.
//  LoadUse = HAZ_EN & MtoRFSelE & RFWEE & (RtE != 0) & (RtE == RsD | RtE == RtD)
//   (MtoRFSelE and RFWEE are internal EX-stage bits).
//  Priority, evaluated each cycle:
//   1. BranchTakenE: FlushD = 1, StallF = StallD = 0, ID/EX loads a bubble, FlushCnt += 1.
//      IllegalOp is not set by the squashed ID instruction.
//   2. LoadUse: StallF = StallD = 1, FlushD = 0, ID/EX loads a bubble, StallCnt += 1.
//      A j held in ID keeps JumpD = 1 but does not flush.
//   3. Otherwise ID/EX loads the decode. FlushD = JumpD; if JumpD, FlushCnt += 1.
//      If the ID instruction is illegal, IllegalOp is set to 1 at the next edge.
//  IllegalOp stays set until reset.
//  Counters hold at all-ones and never wrap.
// TESTING
//  1. add (0,0x20) then lw (0x23) -> next cycle ALUControlE=000 RFDSelInE=1;
//     cycle +3 RFWEW=1 for add; lw gives MtoRFSelW=1 at +3.
//  2. lw with RtE=5 in EX, ID sub with RsD=5 -> StallF=StallD=1 for 1 cycle, bubble in EX,
//     StallCnt=1; repeat with RtE=0 -> no stall.
//  3. beq in EX with BranchTakenE=1 while ID holds opcode 0x3F -> FlushD=1, E outputs 0 next
//     cycle, IllegalOp stays 0, FlushCnt=1.
//  4. Opcode 0x3F unflushed -> IllegalOp=1 next edge, all E/M/W enables 0 for that instruction;
//     IllegalOp persists through 10 further valid instructions.
//  5. BranchTakenE and LoadUse in the same cycle -> StallF=0, FlushD=1, FlushCnt+1, StallCnt
//     unchanged. CNT_W=2 with 5 stalls -> StallCnt=3.
//  6. RST_N low mid-stream between clock edges -> all registered outputs 0 immediately;
//     after release the first instruction reaches the W outputs 3 cycles later.

Source files
------------

// File: rtl/pipe_control_unit_if.sv
// Control-unit bus: the ID-stage instruction fields and hazard inputs coming
// from the pipeline, and the decoded and pipelined control bits going back.
//   master : pipeline side (drives Opcode/Funct/RsD/RtD/RtE/BranchTakenE)
//   slave  : pipe_control_unit (drives stall/flush, stage controls, counters)
interface pipe_control_unit_if #(
  parameter int ALU_W = 3,
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic [5:0]       Opcode;
  logic [5:0]       Funct;
  logic [REG_W-1:0] RsD;
  logic [REG_W-1:0] RtD;
  logic [REG_W-1:0] RtE;
  logic             BranchTakenE;
  logic             JumpD;
  logic             StallF;
  logic             StallD;
  logic             FlushD;
  logic [ALU_W-1:0] ALUControlE;
  logic             ALUMUXInSelE;
  logic             RFDSelInE;
  logic             BranchE;
  logic             RFWEM;
  logic             DMWEM;
  logic             RFWEW;
  logic             MtoRFSelW;
  logic             IllegalOp;
  logic [CNT_W-1:0] StallCnt;
  logic [CNT_W-1:0] FlushCnt;

  modport master (
    output Opcode, Funct, RsD, RtD, RtE, BranchTakenE,
    input  JumpD, StallF, StallD, FlushD, ALUControlE, ALUMUXInSelE, RFDSelInE,
           BranchE, RFWEM, DMWEM, RFWEW, MtoRFSelW, IllegalOp, StallCnt, FlushCnt
  );

  modport slave (
    input  Opcode, Funct, RsD, RtD, RtE, BranchTakenE,
    output JumpD, StallF, StallD, FlushD, ALUControlE, ALUMUXInSelE, RFDSelInE,
           BranchE, RFWEM, DMWEM, RFWEW, MtoRFSelW, IllegalOp, StallCnt, FlushCnt
  );
endinterface

// File: rtl/pipe_control_unit.sv
// Pipelined control unit. Decodes Opcode/Funct in ID, carries the control
// bundle through ID/EX, EX/MEM and MEM/WB, and generates load-use stalls,
// branch/jump flushes, a sticky illegal-opcode flag and saturating
// stall/flush cycle counters.
// Ports:
//   CLK   : rising-edge clock
//   RST_N : asynchronous active-low reset, clears all state to a bubble
//   bus   : pipe_control_unit_if.slave (instruction fields in, controls out)
module pipe_control_unit #(
  parameter int ALU_W  = 3,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16,
  parameter bit HAZ_EN = 1'b1
) (
  input logic                CLK,
  input logic                RST_N,
  pipe_control_unit_if.slave bus
);
  typedef struct packed {
    logic             rfwe;
    logic             dmwe;
    logic             alusrc;
    logic             mtorf;
    logic             regdst;
    logic             branch;
    logic [ALU_W-1:0] alu;
  } ctl_t;

  typedef struct packed {
    logic rfwe;
    logic dmwe;
    logic mtorf;
  } mem_t;

  typedef struct packed {
    logic rfwe;
    logic mtorf;
  } wb_t;

  // f = {rfwe, dmwe, alusrc, mtorf, regdst, branch}
  function automatic ctl_t mk(input logic [5:0] f, input logic [2:0] alu);
    ctl_t c;
    c.rfwe   = f[5];
    c.dmwe   = f[4];
    c.alusrc = f[3];
    c.mtorf  = f[2];
    c.regdst = f[1];
    c.branch = f[0];
    c.alu    = ALU_W'(alu);
    return c;
  endfunction

  ctl_t             dec, id_ex, id_ex_d;
  mem_t             ex_mem;
  wb_t              mem_wb;
  logic             jump, illegal, load_use, br_taken;
  logic             stall_inc, flush_inc, set_ill;
  logic             illegal_op;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  always_comb begin
    dec     = '0;
    jump    = 1'b0;
    illegal = 1'b0;
    case (bus.Opcode)
      6'h00: begin
        case (bus.Funct)
          6'h20:   dec = mk(6'b100010, 3'b000);
          6'h22:   dec = mk(6'b100010, 3'b010);
          6'h00:   dec = mk(6'b100010, 3'b101);
          6'h04:   dec = mk(6'b100010, 3'b110);
          6'h07:   dec = mk(6'b100010, 3'b111);
          default: illegal = 1'b1;
        endcase
      end
      6'h23:   dec = mk(6'b101100, 3'b000);
      6'h2B:   dec = mk(6'b011000, 3'b000);
      6'h08:   dec = mk(6'b101000, 3'b000);
      6'h04:   dec = mk(6'b000001, 3'b010);
      6'h02:   jump = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

  // A load in EX whose destination feeds the ID instruction; r0 never hazards.
  assign load_use = HAZ_EN && id_ex.mtorf && id_ex.rfwe && (bus.RtE != '0) &&
                    ((bus.RtE == bus.RsD) || (bus.RtE == bus.RtD));
  assign br_taken = bus.BranchTakenE;

  // A taken branch outranks the stall: the stalled ID instruction is on the
  // wrong path anyway. A jump waiting behind a stall flushes only once it moves.
  assign stall_inc = !br_taken && load_use;
  assign flush_inc = br_taken || (!load_use && jump);
  assign set_ill   = !br_taken && !load_use && illegal;
  assign id_ex_d   = (br_taken || load_use) ? ctl_t'('0) : dec;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      id_ex      <= '0;
      ex_mem     <= '0;
      mem_wb     <= '0;
      illegal_op <= 1'b0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else begin
      id_ex      <= id_ex_d;
      ex_mem     <= '{rfwe: id_ex.rfwe, dmwe: id_ex.dmwe, mtorf: id_ex.mtorf};
      mem_wb     <= '{rfwe: ex_mem.rfwe, mtorf: ex_mem.mtorf};
      if (set_ill) illegal_op <= 1'b1;
      if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign bus.JumpD        = jump;
  assign bus.StallF       = stall_inc;
  assign bus.StallD       = stall_inc;
  assign bus.FlushD       = flush_inc;
  assign bus.ALUControlE  = id_ex.alu;
  assign bus.ALUMUXInSelE = id_ex.alusrc;
  assign bus.RFDSelInE    = id_ex.regdst;
  assign bus.BranchE      = id_ex.branch;
  assign bus.RFWEM        = ex_mem.rfwe;
  assign bus.DMWEM        = ex_mem.dmwe;
  assign bus.RFWEW        = mem_wb.rfwe;
  assign bus.MtoRFSelW    = mem_wb.mtorf;
  assign bus.IllegalOp    = illegal_op;
  assign bus.StallCnt     = stall_cnt;
  assign bus.FlushCnt     = flush_cnt;
endmodule

// File: tb/tb_pipe_control_unit.sv
// Bench for pipe_control_unit: directed scenarios with literal expectations,
// then randomized instruction streams with async reset pulses, all compared
// every cycle against a table-driven reference model. A second instance with
// CNT_W=2 exercises counter saturation.
module tb_pipe_control_unit;
  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [5:0] op_r = 6'h00, fn_r = 6'h20;
  logic [4:0] rs_r = '0, rt_r = '0, rte_r = '0;
  logic       br_r = 1'b0;
  int         n_tests = 0, n_fail = 0;
  bit         cmp_en = 1'b1;

  always #5 CLK = ~CLK;

  pipe_control_unit_if #(.ALU_W(3), .REG_W(5), .CNT_W(16)) bus1 ();
  pipe_control_unit_if #(.ALU_W(3), .REG_W(5), .CNT_W(2))  bus2 ();

  assign bus1.Opcode = op_r;  assign bus2.Opcode = op_r;
  assign bus1.Funct  = fn_r;  assign bus2.Funct  = fn_r;
  assign bus1.RsD    = rs_r;  assign bus2.RsD    = rs_r;
  assign bus1.RtD    = rt_r;  assign bus2.RtD    = rt_r;
  assign bus1.RtE    = rte_r; assign bus2.RtE    = rte_r;
  assign bus1.BranchTakenE = br_r;
  assign bus2.BranchTakenE = br_r;

  pipe_control_unit #(.ALU_W(3), .REG_W(5), .CNT_W(16), .HAZ_EN(1'b1)) dut (
    .CLK(CLK), .RST_N(RST_N), .bus(bus1));
  pipe_control_unit #(.ALU_W(3), .REG_W(5), .CNT_W(2), .HAZ_EN(1'b1)) dut2 (
    .CLK(CLK), .RST_N(RST_N), .bus(bus2));

  // Reference decode table; control word = {rfwe,dmwe,alusrc,mtorf,regdst,branch,alu[2:0]}
  localparam logic [5:0] T_OP [10] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                                       6'h23, 6'h2B, 6'h08, 6'h04, 6'h02};
  localparam logic [5:0] T_FN [10] = '{6'h20, 6'h22, 6'h00, 6'h04, 6'h07,
                                       6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
  localparam logic [8:0] T_CT [10] = '{9'b100010000, 9'b100010010, 9'b100010101,
                                       9'b100010110, 9'b100010111, 9'b101100000,
                                       9'b011000000, 9'b101000000, 9'b000001010,
                                       9'b000000000};

  // Model state: control words sitting in E, M, W plus flag and counters.
  logic [8:0] e_c = '0, m_c = '0, w_c = '0;
  bit         ill = 1'b0;
  int         sc = 0, fc = 0, sc2 = 0, fc2 = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void lookup(input logic [5:0] o, input logic [5:0] f,
                                 output logic [8:0] c, output bit jmp, output bit legal);
    c = '0; jmp = 1'b0; legal = 1'b0;
    for (int i = 0; i < 10; i++)
      if (o == T_OP[i] && (o != 6'h00 || f == T_FN[i])) begin
        c = T_CT[i]; jmp = (o == 6'h02); legal = 1'b1;
      end
  endfunction

  // What this cycle's inputs imply, by the priority rules.
  function automatic void model_eval(input logic [8:0] e, output bit jmp, output bit stl,
                                     output bit fl, output bit il, output logic [8:0] nxt);
    logic [8:0] c;
    bit legal, lu;
    lookup(op_r, fn_r, c, jmp, legal);
    lu = e[5] && e[8] && rte_r != 0 && (rte_r == rs_r || rte_r == rt_r);
    if (br_r)    begin stl = 1'b0; fl = 1'b1; nxt = '0; il = 1'b0; end
    else if (lu) begin stl = 1'b1; fl = 1'b0; nxt = '0; il = 1'b0; end
    else         begin stl = 1'b0; fl = jmp;  nxt = c;  il = !legal; end
  endfunction

  always @(posedge CLK or negedge RST_N) begin
    bit jmp, stl, fl, il;
    logic [8:0] nxt;
    if (!RST_N) begin
      e_c = '0; m_c = '0; w_c = '0; ill = 1'b0; sc = 0; fc = 0; sc2 = 0; fc2 = 0;
    end else begin
      model_eval(e_c, jmp, stl, fl, il, nxt);
      w_c = m_c; m_c = e_c; e_c = nxt;
      if (il) ill = 1'b1;
      if (stl) begin if (sc < 65535) sc++; if (sc2 < 3) sc2++; end
      if (fl)  begin if (fc < 65535) fc++; if (fc2 < 3) fc2++; end
    end
  end

  always @(negedge CLK) begin
    bit jmp, stl, fl, il;
    logic [8:0] nxt;
    if (cmp_en) begin
      model_eval(e_c, jmp, stl, fl, il, nxt);
      chk("JumpD",        32'(bus1.JumpD),        32'(jmp));
      chk("StallF",       32'(bus1.StallF),       32'(stl));
      chk("StallD",       32'(bus1.StallD),       32'(stl));
      chk("FlushD",       32'(bus1.FlushD),       32'(fl));
      chk("ALUControlE",  32'(bus1.ALUControlE),  32'(e_c[2:0]));
      chk("ALUMUXInSelE", 32'(bus1.ALUMUXInSelE), 32'(e_c[6]));
      chk("RFDSelInE",    32'(bus1.RFDSelInE),    32'(e_c[4]));
      chk("BranchE",      32'(bus1.BranchE),      32'(e_c[3]));
      chk("RFWEM",        32'(bus1.RFWEM),        32'(m_c[8]));
      chk("DMWEM",        32'(bus1.DMWEM),        32'(m_c[7]));
      chk("RFWEW",        32'(bus1.RFWEW),        32'(w_c[8]));
      chk("MtoRFSelW",    32'(bus1.MtoRFSelW),    32'(w_c[5]));
      chk("IllegalOp",    32'(bus1.IllegalOp),    32'(ill));
      chk("StallCnt",     32'(bus1.StallCnt),     32'(sc));
      chk("FlushCnt",     32'(bus1.FlushCnt),     32'(fc));
      chk("StallCnt2",    32'(bus2.StallCnt),     32'(sc2));
      chk("FlushCnt2",    32'(bus2.FlushCnt),     32'(fc2));
    end
  end

  // Apply inputs and wait for the mid-cycle sample point.
  task automatic step(input logic [5:0] o, input logic [5:0] f, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rte, input logic b);
    op_r = o; fn_r = f; rs_r = rs; rt_r = rt; rte_r = rte; br_r = b;
    @(negedge CLK);
  endtask

  task automatic adv();
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    op_r = 6'h00; fn_r = 6'h20; rs_r = '0; rt_r = '0; rte_r = '0; br_r = 1'b0;
    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    #3 RST_N = 1'b1;
    adv();
  endtask

  task automatic filler();
    step(6'h00, 6'h20, 5'd1, 5'd1, 5'd0, 1'b0);
    adv();
  endtask

  initial begin
    // Reset state
    @(posedge CLK); #1;
    chk("rst_ALUControlE", 32'(bus1.ALUControlE), 0);
    chk("rst_RFWEW",       32'(bus1.RFWEW), 0);
    chk("rst_IllegalOp",   32'(bus1.IllegalOp), 0);
    chk("rst_StallCnt",    32'(bus1.StallCnt), 0);
    #3 RST_N = 1'b1;
    adv();

    // add then lw through the pipe
    do_reset();
    step(6'h00, 6'h20, 5'd1, 5'd2, 5'd0, 1'b0); adv();
    chk("t1_add_ALUE", 32'(bus1.ALUControlE), 0);
    chk("t1_add_RFDSel", 32'(bus1.RFDSelInE), 1);
    step(6'h23, 6'h00, 5'd1, 5'd3, 5'd0, 1'b0); adv();
    chk("t1_lw_ALUSrcE", 32'(bus1.ALUMUXInSelE), 1);
    chk("t1_add_RFWEM", 32'(bus1.RFWEM), 1);
    filler();
    chk("t1_add_RFWEW", 32'(bus1.RFWEW), 1);
    chk("t1_add_MtoRFW", 32'(bus1.MtoRFSelW), 0);
    filler();
    chk("t1_lw_MtoRFW", 32'(bus1.MtoRFSelW), 1);

    // load-use stall, then r0 destination does not stall
    do_reset();
    step(6'h23, 6'h00, 5'd0, 5'd5, 5'd0, 1'b0); adv();
    step(6'h00, 6'h22, 5'd5, 5'd1, 5'd5, 1'b0);
    chk("t2_StallF", 32'(bus1.StallF), 1);
    chk("t2_StallD", 32'(bus1.StallD), 1);
    chk("t2_FlushD", 32'(bus1.FlushD), 0);
    adv();
    chk("t2_StallCnt", 32'(bus1.StallCnt), 1);
    chk("t2_bubble_RFDSel", 32'(bus1.RFDSelInE), 0);
    step(6'h00, 6'h22, 5'd5, 5'd1, 5'd5, 1'b0);
    chk("t2_resume_StallF", 32'(bus1.StallF), 0);
    adv();
    chk("t2_sub_ALUE", 32'(bus1.ALUControlE), 2);
    step(6'h23, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0); adv();
    step(6'h00, 6'h22, 5'd0, 5'd1, 5'd0, 1'b0);
    chk("t2_r0_StallF", 32'(bus1.StallF), 0);
    adv();

    // taken branch squashes an illegal opcode in ID
    do_reset();
    step(6'h04, 6'h00, 5'd1, 5'd2, 5'd0, 1'b0); adv();
    chk("t3_BranchE", 32'(bus1.BranchE), 1);
    step(6'h3F, 6'h00, 5'd1, 5'd2, 5'd0, 1'b1);
    chk("t3_FlushD", 32'(bus1.FlushD), 1);
    chk("t3_StallF", 32'(bus1.StallF), 0);
    adv();
    chk("t3_BranchE_bub", 32'(bus1.BranchE), 0);
    chk("t3_IllegalOp", 32'(bus1.IllegalOp), 0);
    chk("t3_FlushCnt", 32'(bus1.FlushCnt), 1);

    // branch beats load-use; then counter saturation on the narrow instance
    do_reset();
    step(6'h23, 6'h00, 5'd0, 5'd5, 5'd0, 1'b0); adv();
    step(6'h00, 6'h22, 5'd5, 5'd1, 5'd5, 1'b1);
    chk("t5_StallF", 32'(bus1.StallF), 0);
    chk("t5_FlushD", 32'(bus1.FlushD), 1);
    adv();
    chk("t5_FlushCnt", 32'(bus1.FlushCnt), 1);
    chk("t5_StallCnt", 32'(bus1.StallCnt), 0);
    for (int i = 0; i < 5; i++) begin
      step(6'h23, 6'h00, 5'd0, 5'd5, 5'd0, 1'b0); adv();
      step(6'h00, 6'h22, 5'd5, 5'd1, 5'd5, 1'b0); adv();
      step(6'h00, 6'h22, 5'd5, 5'd1, 5'd5, 1'b0); adv();
    end
    chk("t5_StallCnt5", 32'(bus1.StallCnt), 5);
    chk("t5_sat_StallCnt2", 32'(bus2.StallCnt), 3);

    // illegal opcode traps and sticks
    do_reset();
    step(6'h3F, 6'h00, 5'd1, 5'd2, 5'd0, 1'b0); adv();
    chk("t4_IllegalOp", 32'(bus1.IllegalOp), 1);
    chk("t4_ALUSrcE", 32'(bus1.ALUMUXInSelE), 0);
    chk("t4_RFDSelE", 32'(bus1.RFDSelInE), 0);
    filler();
    chk("t4_RFWEM", 32'(bus1.RFWEM), 0);
    chk("t4_DMWEM", 32'(bus1.DMWEM), 0);
    filler();
    chk("t4_RFWEW", 32'(bus1.RFWEW), 0);
    for (int i = 0; i < 10; i++) filler();
    chk("t4_sticky", 32'(bus1.IllegalOp), 1);

    // async reset mid-stream, then refill
    filler(); filler();
    #2 RST_N = 1'b0;
    #1;
    chk("t6_RFWEM", 32'(bus1.RFWEM), 0);
    chk("t6_RFWEW", 32'(bus1.RFWEW), 0);
    chk("t6_IllegalOp", 32'(bus1.IllegalOp), 0);
    chk("t6_FlushCnt", 32'(bus1.FlushCnt), 0);
    op_r = 6'h00; fn_r = 6'h20; rs_r = 5'd1; rt_r = 5'd2; rte_r = '0; br_r = 1'b0;
    #4 RST_N = 1'b1;
    adv();
    step(6'h2B, 6'h00, 5'd1, 5'd2, 5'd0, 1'b0); adv();
    chk("t6_W_early", 32'(bus1.RFWEW), 0);
    step(6'h2B, 6'h00, 5'd1, 5'd2, 5'd0, 1'b0); adv();
    chk("t6_W_add", 32'(bus1.RFWEW), 1);

    // randomized stream with occasional async reset pulses
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 39);
      if (r < 38) begin
        op_r = T_OP[r % 10]; fn_r = T_FN[r % 10];
      end else if (r == 38) begin
        op_r = 6'($urandom); fn_r = 6'($urandom);
      end else begin
        op_r = 6'h00; fn_r = 6'($urandom);
      end
      rs_r  = 5'($urandom_range(0, 3));
      rt_r  = 5'($urandom_range(0, 3));
      rte_r = 5'($urandom_range(0, 3));
      br_r  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 249) == 0) begin
        RST_N = 1'b0;
        @(posedge CLK);
        #2 RST_N = 1'b1;
      end
      adv();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
